// File: rtl/alu_pkg.sv
// Opcode type and constants shared by the alu datapath and its register stage.
package alu_pkg;

   typedef logic [0:2] opcode_t;

   localparam opcode_t OP_HLT = 3'b000;
   localparam opcode_t OP_SKZ = 3'b001;
   localparam opcode_t OP_ADD = 3'b010;
   localparam opcode_t OP_AND = 3'b011;
   localparam opcode_t OP_XOR = 3'b100;
   localparam opcode_t OP_LDA = 3'b101;
   localparam opcode_t OP_STO = 3'b110;
   localparam opcode_t OP_JMP = 3'b111;

endpackage

// File: rtl/alu_comb.sv
// Combinational result select, accumulator zero detect and optional ADD carry.
// Carry output exists only when ALU_CARRY_EN is defined.
module alu_comb
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [0:WIDTH-1] a_i,
   input  logic [0:WIDTH-1] b_i,
   input  opcode_t          op_i,
`ifdef ALU_CARRY_EN
   output logic             carry_o,
`endif
   output logic [0:WIDTH-1] result_o,
   output logic             a_zero_o
);

`ifdef ALU_CARRY_EN
   // Extra leading bit holds the carry out of the MSB.
   logic [0:WIDTH] sum_ext;
   logic [0:WIDTH-1] sum;
   assign sum_ext = {1'b0, a_i} + {1'b0, b_i};
   assign sum     = sum_ext[1:WIDTH];
   assign carry_o = (op_i == OP_ADD) ? sum_ext[0] : 1'b0;
`else
   logic [0:WIDTH-1] sum;
   assign sum = a_i + b_i;
`endif

   assign a_zero_o = (a_i == '0);

   always_comb begin
      result_o = a_i;
      unique case (op_i)
         OP_HLT:  result_o = a_i;
         OP_SKZ:  result_o = a_i;
         OP_ADD:  result_o = sum;
         OP_AND:  result_o = a_i & b_i;
         OP_XOR:  result_o = a_i ^ b_i;
         OP_LDA:  result_o = b_i;
         OP_STO:  result_o = a_i;
         OP_JMP:  result_o = a_i;
      endcase
   end

endmodule

// File: rtl/alu.sv
// Accumulator-machine ALU: registers the alu_comb result and zero flag each clock.
// Define ALU_CARRY_EN to add the registered carry_out port.
module alu
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [0:WIDTH-1] in_a,
   input  logic [0:WIDTH-1] in_b,
   input  opcode_t          opcode,
`ifdef ALU_CARRY_EN
   output logic             carry_out,
`endif
   output logic [0:WIDTH-1] alu_out,
   output logic             a_is_zero
);

   logic [0:WIDTH-1] alu_out_d, alu_out_q;
   logic             a_is_zero_d, a_is_zero_q;

`ifdef ALU_CARRY_EN
   logic carry_d, carry_q;
`endif

   alu_comb #(
      .WIDTH (WIDTH)
   ) u_alu_comb (
      .a_i      (in_a),
      .b_i      (in_b),
      .op_i     (opcode),
`ifdef ALU_CARRY_EN
      .carry_o  (carry_d),
`endif
      .result_o (alu_out_d),
      .a_zero_o (a_is_zero_d)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_out_q   <= '0;
         a_is_zero_q <= 1'b0;
`ifdef ALU_CARRY_EN
         carry_q     <= 1'b0;
`endif
      end else begin
         alu_out_q   <= alu_out_d;
         a_is_zero_q <= a_is_zero_d;
`ifdef ALU_CARRY_EN
         carry_q     <= carry_d;
`endif
      end
   end

   assign alu_out   = alu_out_q;
   assign a_is_zero = a_is_zero_q;
`ifdef ALU_CARRY_EN
   assign carry_out = carry_q;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu at WIDTH=4 with a plain-arithmetic reference model.
// Exercises carry_out as well when ALU_CARRY_EN is defined.
module tb_alu;

   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [0:W-1] in_a;
   logic [0:W-1] in_b;
   logic [0:2]   opcode;
   logic [0:W-1] alu_out;
   logic         a_is_zero;
`ifdef ALU_CARRY_EN
   logic         carry_out;
`endif

   int checks = 0;
   int errors = 0;

   alu #(
      .WIDTH (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_a      (in_a),
      .in_b      (in_b),
      .opcode    (opcode),
`ifdef ALU_CARRY_EN
      .carry_out (carry_out),
`endif
      .alu_out   (alu_out),
      .a_is_zero (a_is_zero)
   );

   always #5 clk = ~clk;

   // Reference: result from instruction semantics using integer arithmetic.
   function automatic int model_res(int a, int b, int op);
      case (op)
         2:       return (a + b) % 16;
         3:       return a & b;
         4:       return a ^ b;
         5:       return b;
         default: return a;
      endcase
   endfunction

   function automatic int model_carry(int a, int b, int op);
      return (op == 2) ? (a + b) / 16 : 0;
   endfunction

   task automatic drive(input int a, input int b, input int op);
      in_a   = 4'(a);
      in_b   = 4'(b);
      opcode = 3'(op);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(6, 3, 2);
      step();
      step();
      checks++;
      if (alu_out !== 4'b0000) begin
         errors++;
         $display("FAIL reset_alu_out got=%b want=0000", alu_out);
      end
      checks++;
      if (a_is_zero !== 1'b0) begin
         errors++;
         $display("FAIL reset_a_is_zero got=%b want=0", a_is_zero);
      end
`ifdef ALU_CARRY_EN
      checks++;
      if (carry_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_carry got=%b want=0", carry_out);
      end
`endif
      rst = 1'b0;
      step();
      checks++;
      if (alu_out !== 4'b1001) begin
         errors++;
         $display("FAIL post_reset_add got=%b want=1001", alu_out);
      end
      // Reset mid-stream discards the pending result.
      drive(5, 1, 5);
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (alu_out !== 4'b0000 || a_is_zero !== 1'b0) begin
         errors++;
         $display("FAIL midstream_reset got=%b/%b want=0000/0", alu_out, a_is_zero);
      end
   endtask

   task automatic test_pass_through();
      int ops[4] = '{0, 1, 6, 7};
      foreach (ops[i]) begin
         drive(2, 4, ops[i]);
         step();
         checks++;
         if (alu_out !== 4'b0010 || a_is_zero !== 1'b0) begin
            errors++;
            $display("FAIL pass_op%0d got=%b/%b want=0010/0", ops[i], alu_out, a_is_zero);
         end
      end
   endtask

   task automatic test_arith_logic();
      int a_v[3]   = '{1, 6, 6};
      int b_v[3]   = '{3, 4, 4};
      int op_v[3]  = '{2, 3, 4};
      int exp_v[3] = '{4, 4, 2};
      for (int i = 0; i < 3; i++) begin
         drive(a_v[i], b_v[i], op_v[i]);
         step();
         checks++;
         if (alu_out !== 4'(exp_v[i]) || a_is_zero !== 1'b0) begin
            errors++;
            $display("FAIL arith_op%0d got=%b/%b want=%b/0", op_v[i], alu_out, a_is_zero,
                     4'(exp_v[i]));
         end
      end
   endtask

   task automatic test_lda();
      drive(6, 4, 5);
      step();
      checks++;
      if (alu_out !== 4'b0100) begin
         errors++;
         $display("FAIL lda got=%b want=0100", alu_out);
      end
   endtask

   task automatic test_zero_wrap();
      drive(0, 4, 7);
      step();
      checks++;
      if (alu_out !== 4'b0000 || a_is_zero !== 1'b1) begin
         errors++;
         $display("FAIL zero_flag got=%b/%b want=0000/1", alu_out, a_is_zero);
      end
      drive(15, 1, 2);
      step();
      checks++;
      if (alu_out !== 4'b0000 || a_is_zero !== 1'b0) begin
         errors++;
         $display("FAIL add_wrap got=%b/%b want=0000/0", alu_out, a_is_zero);
      end
`ifdef ALU_CARRY_EN
      checks++;
      if (carry_out !== 1'b1) begin
         errors++;
         $display("FAIL add_wrap_carry got=%b want=1", carry_out);
      end
`endif
   endtask

   task automatic test_back_to_back();
      int a, b, op, er, ez;
      for (int i = 0; i < 64; i++) begin
         a  = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 15));
         b  = int'($urandom_range(0, 15));
         op = (i + i / 8) % 8;
         er = model_res(a, b, op);
         ez = (a == 0) ? 1 : 0;
         drive(a, b, op);
         step();
         checks++;
         if (alu_out !== 4'(er) || a_is_zero !== 1'(ez)) begin
            errors++;
            $display("FAIL b2b_%0d op=%0d a=%0d b=%0d got=%b/%b want=%b/%0d", i, op, a, b,
                     alu_out, a_is_zero, 4'(er), ez);
         end
`ifdef ALU_CARRY_EN
         checks++;
         if (carry_out !== 1'(model_carry(a, b, op))) begin
            errors++;
            $display("FAIL b2b_carry_%0d got=%b want=%0d", i, carry_out, model_carry(a, b, op));
         end
`endif
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(0, 0, 0);
      test_reset();
      test_pass_through();
      test_arith_logic();
      test_lda();
      test_zero_wrap();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
